ysyx_22041207_mul_arb: RTL and testbench

//  Shares one iterative 64x64 multiplier among NREQ requesters (e.g. EXU issue slots).

---
 rtl/ysyx_22041207_mul_arb.sv | 168 ++++++++++++++++
 tb/tb_ysyx_22041207_mul_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_mul_arb.sv
// ysyx_22041207_mul_arb: round-robin arbiter that shares one iterative 64x64
// multiplier among NREQ requesters and returns each product to its owner over
// a valid/ready response channel. One operation is in flight at a time.
// Optional feature: define YSYX_22041207_MUL_ARB_CACHE_EN to add a one-entry
// result cache that answers a repeated operand pair without using the multiplier.
module ysyx_22041207_mul_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*64-1:0]   req_a,
    input  logic [NREQ*64-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_kill,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_hi,
    output logic [31:0]          resp_lo,
    output logic                 m_valid,
    output logic [63:0]          m_a,
    output logic [63:0]          m_b,
    input  logic                 m_ready,
    input  logic                 m_out_valid,
    input  logic [31:0]          m_hi,
    input  logic [31:0]          m_lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             killed_q, killed_d;
    logic [63:0]      res_q, res_d;

    logic [NREQ-1:0]  elig;
    logic             any_elig;
    logic [IDX_W-1:0] win;
    logic [63:0]      win_a, win_b;
    logic             hit;
    logic [63:0]      hit_res;
    logic             grant;

    assign elig  = req_valid & ~req_kill;
    assign win_a = req_a[64*int'(win) +: 64];
    assign win_b = req_b[64*int'(win) +: 64];

    // Round-robin pick: scan from farthest to nearest so the first eligible
    // index after last_q is the one left in win.
    always_comb begin
        int idx;
        win      = '0;
        any_elig = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NREQ;
            if (elig[idx]) begin
                win      = IDX_W'(idx);
                any_elig = 1'b1;
            end
        end
    end

`ifdef YSYX_22041207_MUL_ARB_CACHE_EN
    logic        cv_q;
    logic [63:0] ca_q, cb_q, cres_q;
    logic [63:0] opa_q, opb_q;

    assign hit     = cv_q && (win_a == ca_q) && (win_b == cb_q);
    assign hit_res = cres_q;

    // Remember operands of the in-flight op; every drained result (killed
    // ones too) refreshes the cache entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cv_q   <= 1'b0;
            ca_q   <= '0;
            cb_q   <= '0;
            cres_q <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else begin
            if (m_valid) begin
                opa_q <= win_a;
                opb_q <= win_b;
            end
            if (state_q == S_BUSY && m_out_valid) begin
                cv_q   <= 1'b1;
                ca_q   <= opa_q;
                cb_q   <= opb_q;
                cres_q <= {m_hi, m_lo};
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    // A cache hit needs no multiplier, so m_ready only gates real issues.
    assign grant      = (state_q == S_IDLE) && !rst && any_elig && (m_ready || hit);
    assign req_ready  = grant ? (ONE << win) : '0;
    assign m_valid    = grant && !hit;
    assign m_a        = m_valid ? win_a : '0;
    assign m_b        = m_valid ? win_b : '0;
    assign resp_valid = (state_q == S_RESP) ? (ONE << owner_q) : '0;
    assign resp_hi    = res_q[63:32];
    assign resp_lo    = res_q[31:0];

    // Next-state: grant in IDLE, drain the multiplier in BUSY (kill only
    // suppresses the response), hold the result in RESP until taken or killed.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        killed_d = killed_q;
        res_d    = res_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    owner_d = win;
                    last_d  = win;
                    if (hit) begin
                        res_d   = hit_res;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (req_kill[owner_q]) killed_d = 1'b1;
                if (m_out_valid) begin
                    res_d   = {m_hi, m_lo};
                    state_d = (killed_q || req_kill[owner_q]) ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                if (req_kill[owner_q] || resp_ready[owner_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != S_BUSY) killed_d = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            killed_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            killed_q <= killed_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_mul_arb.sv
// Directed bench for ysyx_22041207_mul_arb with a fixed-latency multiplier
// stand-in. Expected values are hand-computed constants.
module tb_ysyx_22041207_mul_arb;

    localparam int NREQ = 2;
    localparam int LAT  = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid, req_ready, req_kill, resp_valid, resp_ready;
    logic [NREQ*64-1:0] req_a, req_b;
    logic [31:0]        resp_hi, resp_lo, m_hi, m_lo;
    logic               m_valid, m_ready, m_out_valid;
    logic [63:0]        m_a, m_b;

    always #5 clk = ~clk;

    ysyx_22041207_mul_arb #(.NREQ(NREQ), .IDX_W(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .req_kill(req_kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hi(resp_hi), .resp_lo(resp_lo),
        .m_valid(m_valid), .m_a(m_a), .m_b(m_b), .m_ready(m_ready),
        .m_out_valid(m_out_valid), .m_hi(m_hi), .m_lo(m_lo)
    );

    // Iterative multiplier stand-in: LAT cycles, one-cycle done pulse.
    logic        mbusy;
    int          mcnt;
    logic [63:0] mprod;
    assign m_ready = ~mbusy;
    always @(posedge clk) begin
        if (rst) begin
            mbusy       <= 1'b0;
            m_out_valid <= 1'b0;
            mcnt        <= 0;
        end else begin
            m_out_valid <= 1'b0;
            if (m_valid && !mbusy) begin
                mbusy <= 1'b1;
                mcnt  <= LAT;
                mprod <= m_a * m_b;
            end else if (mbusy) begin
                if (mcnt == 1) begin
                    mbusy       <= 1'b0;
                    m_out_valid <= 1'b1;
                    {m_hi, m_lo} <= mprod;
                end
                mcnt <= mcnt - 1;
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    int   gq[$];
    int   rq_lo[$];
    int   rv0, ov;
    logic outst;
    always @(negedge clk) begin
        if (rst) begin
            gq.delete(); rq_lo.delete();
            rv0 = 0; ov = 0; outst = 1'b0;
        end else begin
            if (|req_ready) begin
                gq.push_back(req_ready[1] ? 1 : 0);
                if (outst) ov++;
                outst = 1'b1;
            end
            if (|(resp_valid & resp_ready)) begin
                rq_lo.push_back(int'(resp_lo));
                outst = 1'b0;
            end
            if (resp_valid[0]) rv0++;
        end
    end

    int npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = '0; req_kill = '0; resp_ready = '1;
        req_a = '0; req_b = '0;
        tick; tick;
        rst = 1'b0; #1;
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return m_out_valid;
            1:       return resp_valid[0];
            default: return resp_valid[1];
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sig(which)) return;
            tick;
        end
        chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int pre;
        // Reset state and single request.
        do_reset;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_res", {resp_hi, resp_lo}, 64'd0);
        req_valid = 2'b01; req_a[63:0] = 64'd3; req_b[63:0] = 64'd5; #1;
        chk("t1_grant", 64'(req_ready), 64'd1);
        chk("t1_m_valid", 64'(m_valid), 64'd1);
        chk("t1_m_a", m_a, 64'd3);
        chk("t1_m_b", m_b, 64'd5);
        tick; req_valid = '0; #1;
        chk("t1_m_valid_pulse", 64'(m_valid), 64'd0);
        wait_for(0, "t1_mov");
        chk("t1_no_early_resp", 64'(resp_valid), 64'd0);
        tick;
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        chk("t1_hi", 64'(resp_hi), 64'h0);
        chk("t1_lo", 64'(resp_lo), 64'hF);
        tick;
        chk("t1_resp_done", 64'(resp_valid), 64'd0);

        // Round-robin with both requesters always pending.
        do_reset;
        req_a = {64'd4, 64'd2}; req_b = {64'd5, 64'd3}; req_valid = 2'b11;
        for (int i = 0; i < 200 && gq.size() < 4; i++) tick;
        req_valid = '0;
        for (int i = 0; i < 200 && rq_lo.size() < 4; i++) tick;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_grant%0d", k), 64'(k < gq.size() ? gq[k] : 9), 64'(k % 2));
            chk($sformatf("t2_lo%0d", k), 64'(k < rq_lo.size() ? rq_lo[k] : 99), (k % 2) ? 64'd20 : 64'd6);
        end
        chk("t2_no_overlap", 64'(ov), 64'd0);

        // Kill while BUSY; req 1 waits for the drain.
        do_reset;
        req_a = {64'd2, 64'd6}; req_b = {64'd9, 64'd7}; req_valid = 2'b11; #1;
        chk("t3_grant0", 64'(req_ready), 64'b01);
        tick; req_valid = 2'b10; req_kill = 2'b01;
        tick; req_kill = '0;
        pre = 0;
        for (int i = 0; i < 60 && !m_out_valid; i++) begin
            if (req_ready != '0) pre++;
            tick;
        end
        chk("t3_drain_seen", 64'(m_out_valid), 64'd1);
        chk("t3_no_early_grant", 64'(pre), 64'd0);
        tick;
        chk("t3_grant1_after_drain", 64'(req_ready), 64'b10);
        tick; req_valid = '0;
        wait_for(2, "t3_resp1");
        chk("t3_lo1", 64'(resp_lo), 64'd18);
        tick;
        chk("t3_no_resp0", 64'(rv0), 64'd0);

        // Backpressure in RESP.
        do_reset;
        req_a = {64'd1, 64'h10000}; req_b = {64'd1, 64'h10001};
        req_valid = 2'b11; resp_ready = '0; #1;
        tick; req_valid = 2'b10;
        wait_for(1, "t4_resp");
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("t4_rv%0d", c), 64'(resp_valid), 64'b01);
            chk($sformatf("t4_hi%0d", c), 64'(resp_hi), 64'h1);
            chk($sformatf("t4_lo%0d", c), 64'(resp_lo), 64'h10000);
            chk($sformatf("t4_mv%0d", c), 64'(m_valid), 64'd0);
            chk($sformatf("t4_rr%0d", c), 64'(req_ready), 64'd0);
            tick;
        end
        resp_ready = '1; #1;
        tick;
        chk("t4_released", 64'(resp_valid), 64'd0);
        chk("t4_grant1", 64'(req_ready), 64'b10);
        tick; req_valid = '0;
        wait_for(2, "t4_resp1");
        chk("t4_lo1", 64'(resp_lo), 64'd1);
        tick;

        // Reset mid-op.
        do_reset;
        req_a[63:0] = 64'd3; req_b[63:0] = 64'd5; req_valid = 2'b01; #1;
        chk("t5_grant", 64'(req_ready), 64'd1);
        tick; req_valid = '0;
        repeat (4) tick;
        chk("t5_busy", 64'(resp_valid), 64'd0);
        rst = 1'b1;
        tick;
        chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
        chk("t5_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("t5_rst_m_valid", 64'(m_valid), 64'd0);
        chk("t5_rst_res", {resp_hi, resp_lo}, 64'd0);
        rst = 1'b0;
        repeat (12) tick;
        chk("t5_no_stale_resp", 64'(rv0), 64'd0);
        req_valid = 2'b01; #1;
        chk("t5_idle_after_rst", 64'(req_ready), 64'd1);
        tick; req_valid = '0;
        wait_for(1, "t5_resp");
        chk("t5_lo", 64'(resp_lo), 64'hF);
        tick;

        // Same operands twice (cache hit when the cache is built in).
        do_reset;
        req_a[63:0] = 64'hFFFF_FFFF_FFFF_FFFE; req_b[63:0] = 64'd7; req_valid = 2'b01; #1;
        chk("t6_first_m_valid", 64'(m_valid), 64'd1);
        tick; req_valid = '0;
        wait_for(1, "t6_resp_a");
        chk("t6_hi_a", 64'(resp_hi), 64'hFFFF_FFFF);
        chk("t6_lo_a", 64'(resp_lo), 64'hFFFF_FFF2);
        tick;
        req_valid = 2'b01; #1;
        chk("t6_grant_b", 64'(req_ready), 64'd1);
`ifdef YSYX_22041207_MUL_ARB_CACHE_EN
        chk("t6_hit_no_m_valid", 64'(m_valid), 64'd0);
        tick; req_valid = '0;
        chk("t6_resp_1cyc", 64'(resp_valid), 64'd1);
`else
        chk("t6_second_m_valid", 64'(m_valid), 64'd1);
        tick; req_valid = '0;
        wait_for(1, "t6_resp_b");
`endif
        chk("t6_hi_b", 64'(resp_hi), 64'hFFFF_FFFF);
        chk("t6_lo_b", 64'(resp_lo), 64'hFFFF_FFF2);
        tick;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
